rr_onehot_arbiter: RTL and testbench

- Round-robin arbiter that sits directly upstream of the 8-to-3 encoder.
- Samples 8 request lines and issues exactly one registered one-hot grant, din-compatible for the encoder.
- Also provides a registered 3-bit index of the granted channel, for cross-checking against the encoder output.
- Grant is delivered over a valid/ready handshake, so the consumer can stall it.

---
 rtl/rr_onehot_arbiter_pkg.sv | 15 +
 rtl/rr_select.sv | 29 ++
 rtl/rr_onehot_arbiter.sv | 81 ++++++++
 tb/tb_rr_onehot_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared constants and types for the round-robin one-hot arbiter.
package rr_onehot_arbiter_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef logic [N-1:0]     vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : rr_onehot_arbiter_pkg

// File: rtl/rr_select.sv
// Combinational round-robin pick: rotate req right by ptr, take lowest set bit, rotate back.
module rr_select
  import rr_onehot_arbiter_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     sel,
  output logic [IDX_W-1:0] sel_idx,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  idx_t           off;

  // Rotate by doubling the vector, then find the first requester at or after ptr
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = idx_t'(i);
    end
    any     = |req;
    sel_idx = any ? idx_t'(ptr + off) : '0;
    sel     = any ? (vec_t'(1) << sel_idx) : '0;
  end

endmodule : rr_select

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter presenting a registered one-hot grant over valid/ready.
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [IDX_W-1:0] ptr_o
);

  state_t state;
  idx_t   ptr;
  logic   accept_c;
  idx_t   sel_ptr_c;
  vec_t   sel_c;
  idx_t   sel_idx_c;
  logic   any_c;

  // On accept the next pick already uses the advanced pointer, so grants flow without a bubble
  always_comb begin
    accept_c  = (state == GRANT) && gnt_ready;
    sel_ptr_c = accept_c ? idx_t'(gnt_idx + idx_t'(1)) : ptr;
  end

  rr_select u_select (
    .req     (req),
    .ptr     (sel_ptr_c),
    .sel     (sel_c),
    .sel_idx (sel_idx_c),
    .any     (any_c)
  );

  // Grant FSM: present a grant, hold it until accepted, then advance the pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_c) begin
            gnt       <= sel_c;
            gnt_idx   <= sel_idx_c;
            gnt_valid <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (gnt_ready) begin
            ptr <= sel_ptr_c;
            if (any_c) begin
              gnt     <= sel_c;
              gnt_idx <= sel_idx_c;
            end else begin
              gnt       <= '0;
              gnt_idx   <= '0;
              gnt_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_idx   <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ptr_o = ptr;

endmodule : rr_onehot_arbiter

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter.
module tb_rr_onehot_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       gnt_ready;
  logic [2:0] ptr_o;

  int checks = 0;
  int passed = 0;

  rr_onehot_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .ptr_o     (ptr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 8'h00;
    gnt_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 8'hFF;
    gnt_ready = 1'b1;
    step();
    step();
    checks++;
    if (gnt !== 8'h00) $display("FAIL reset_gnt: got %b want %b", gnt, 8'h00); else passed++;
    checks++;
    if (gnt_idx !== 3'd0) $display("FAIL reset_idx: got %0d want 0", gnt_idx); else passed++;
    checks++;
    if (gnt_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", gnt_valid); else passed++;
    checks++;
    if (ptr_o !== 3'd0) $display("FAIL reset_ptr: got %0d want 0", ptr_o); else passed++;
    rst_n = 1'b1;
    step();
    checks++;
    if (gnt !== 8'b0000_0001 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1)
      $display("FAIL reset_first_grant: got gnt=%b idx=%0d v=%b want gnt=00000001 idx=0 v=1",
               gnt, gnt_idx, gnt_valid);
    else passed++;
  endtask

  task automatic test_idle_ready();
    do_reset();
    req = 8'h00;
    gnt_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (gnt_valid !== 1'b0 || gnt !== 8'h00 || ptr_o !== 3'd0)
      $display("FAIL idle_ready: got v=%b gnt=%b ptr=%0d want v=0 gnt=0 ptr=0",
               gnt_valid, gnt, ptr_o);
    else passed++;
  endtask

  task automatic test_full_rotation();
    logic [2:0] exp_idx;
    logic [7:0] exp_gnt;
    do_reset();
    req = 8'hFF;
    gnt_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      exp_idx = 3'(k % 8);
      exp_gnt = 8'(1) << exp_idx;
      checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== exp_idx || gnt !== exp_gnt)
        $display("FAIL rotation[%0d]: got v=%b idx=%0d gnt=%b want v=1 idx=%0d gnt=%b",
                 k, gnt_valid, gnt_idx, gnt, exp_idx, exp_gnt);
      else passed++;
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    req = 8'b0000_0100;
    gnt_ready = 1'b0;
    step();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2)
      $display("FAIL stall_first: got v=%b idx=%0d want v=1 idx=2", gnt_valid, gnt_idx);
    else passed++;
    req = 8'b1000_0000;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (gnt !== 8'b0000_0100 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1 || ptr_o !== 3'd0)
        $display("FAIL stall_hold[%0d]: got gnt=%b idx=%0d v=%b ptr=%0d want gnt=00000100 idx=2 v=1 ptr=0",
                 k, gnt, gnt_idx, gnt_valid, ptr_o);
      else passed++;
    end
    gnt_ready = 1'b1;
    step();
    checks++;
    if (gnt_idx !== 3'd7 || gnt !== 8'b1000_0000 || ptr_o !== 3'd3)
      $display("FAIL stall_release: got idx=%0d gnt=%b ptr=%0d want idx=7 gnt=10000000 ptr=3",
               gnt_idx, gnt, ptr_o);
    else passed++;
  endtask

  task automatic test_skip_wrap();
    do_reset();
    req = 8'b0010_0000;
    gnt_ready = 1'b0;
    step();
    req = 8'b0010_0010;
    gnt_ready = 1'b1;
    step();
    checks++;
    if (ptr_o !== 3'd6 || gnt_idx !== 3'd1 || gnt !== 8'b0000_0010)
      $display("FAIL skip_wrap: got ptr=%0d idx=%0d gnt=%b want ptr=6 idx=1 gnt=00000010",
               ptr_o, gnt_idx, gnt);
    else passed++;
    step();
    checks++;
    if (ptr_o !== 3'd2 || gnt_idx !== 3'd5 || gnt !== 8'b0010_0000)
      $display("FAIL skip_next: got ptr=%0d idx=%0d gnt=%b want ptr=2 idx=5 gnt=00100000",
               ptr_o, gnt_idx, gnt);
    else passed++;
  endtask

  task automatic test_sole_requester();
    do_reset();
    req = 8'b0001_0000;
    gnt_ready = 1'b1;
    step();
    checks++;
    if (gnt_idx !== 3'd4 || ptr_o !== 3'd0 || gnt_valid !== 1'b1)
      $display("FAIL sole_first: got idx=%0d ptr=%0d v=%b want idx=4 ptr=0 v=1",
               gnt_idx, ptr_o, gnt_valid);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (gnt_idx !== 3'd4 || gnt !== 8'b0001_0000 || ptr_o !== 3'd5 || gnt_valid !== 1'b1)
        $display("FAIL sole_regrant[%0d]: got idx=%0d gnt=%b ptr=%0d v=%b want idx=4 gnt=00010000 ptr=5 v=1",
                 k, gnt_idx, gnt, ptr_o, gnt_valid);
      else passed++;
    end
    req = 8'h00;
    step();
    checks++;
    if (gnt_valid !== 1'b0 || gnt !== 8'h00 || gnt_idx !== 3'd0 || ptr_o !== 3'd5)
      $display("FAIL sole_drop: got v=%b gnt=%b idx=%0d ptr=%0d want v=0 gnt=0 idx=0 ptr=5",
               gnt_valid, gnt, gnt_idx, ptr_o);
    else passed++;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 8'b0000_1000;
    gnt_ready = 1'b1;
    step();
    step();
    gnt_ready = 1'b0;
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3 || ptr_o !== 3'd4)
      $display("FAIL mid_pre: got v=%b idx=%0d ptr=%0d want v=1 idx=3 ptr=4",
               gnt_valid, gnt_idx, ptr_o);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt_valid !== 1'b0 || gnt !== 8'h00 || gnt_idx !== 3'd0 || ptr_o !== 3'd0)
      $display("FAIL mid_async_clear: got v=%b gnt=%b idx=%0d ptr=%0d want all 0",
               gnt_valid, gnt, gnt_idx, ptr_o);
    else passed++;
    #1;
    rst_n = 1'b1;
    req = 8'b0000_1000;
    step();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3 || gnt !== 8'b0000_1000 || ptr_o !== 3'd0)
      $display("FAIL mid_regrant: got v=%b idx=%0d gnt=%b ptr=%0d want v=1 idx=3 gnt=00001000 ptr=0",
               gnt_valid, gnt_idx, gnt, ptr_o);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 8'h00;
    gnt_ready = 1'b0;
    test_reset();
    test_idle_ready();
    test_full_rotation();
    test_stall_hold();
    test_skip_wrap();
    test_sole_requester();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_rr_onehot_arbiter
